// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one small 5-bit ALU between N_REQ requesters.
// Each operation goes through IDLE (grant/accept), EXEC (compute and register
// the result) and RESP (hold the response until the consumer takes it).
// Optional feature macro: ALU_ARB_RR_EN selects round-robin arbitration.
// Without it, arbitration is fixed priority and the lowest index wins.
module alu_arbiter #(
    parameter int N_REQ = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req_valid,
    output logic [N_REQ-1:0]   req_ready,
    input  logic [3*N_REQ-1:0] req_op,
    input  logic [5*N_REQ-1:0] req_a,
    input  logic [5*N_REQ-1:0] req_b,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [1:0]         rsp_id,
    output logic [5:0]         rsp_data,
    output logic               rsp_ovf,
    output logic               busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t       state;
    state_t       next_state;

    logic [N_REQ-1:0] grant;
    logic [1:0]       grant_idx;
    logic [2:0]       sel_op;
    logic [4:0]       sel_a;
    logic [4:0]       sel_b;
    logic             found;
    int               cand;
    logic             accept;

    logic [2:0]       lat_op;
    logic [4:0]       lat_a;
    logic [4:0]       lat_b;
    logic [1:0]       lat_id;
    logic [5:0]       res_data;
    logic             res_ovf;

    logic [5:0]       alu_sum;
    logic [5:0]       alu_out;

    // Search start index: a real register when round-robin, otherwise tied to 0.
    logic [1:0]       ptr;

`ifdef ALU_ARB_RR_EN
    // Pointer moves just past the requester that was accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= 2'd0;
        end else if (accept) begin
            ptr <= (int'(grant_idx) == N_REQ - 1) ? 2'd0 : grant_idx + 2'd1;
        end
    end
`else
    assign ptr = 2'd0;
`endif

    // Pick the first valid requester starting from ptr and wrapping around.
    always_comb begin
        grant     = '0;
        grant_idx = 2'd0;
        sel_op    = 3'd0;
        sel_a     = 5'd0;
        sel_b     = 5'd0;
        found     = 1'b0;
        cand      = 0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = int'(ptr) + k;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            for (int j = 0; j < N_REQ; j++) begin
                if (!found && (j == cand) && req_valid[j]) begin
                    grant[j]  = 1'b1;
                    grant_idx = 2'(j);
                    sel_op    = req_op[3*j +: 3];
                    sel_a     = req_a[5*j +: 5];
                    sel_b     = req_b[5*j +: 5];
                    found     = 1'b1;
                end
            end
        end
    end

    assign accept = (state == IDLE) && (|grant);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state: EXEC is always exactly one cycle, RESP waits for rsp_ready.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept)    next_state = EXEC;
            EXEC:                   next_state = RESP;
            RESP:    if (rsp_ready) next_state = IDLE;
            default:                next_state = IDLE;
        endcase
    end

    // ALU on the latched operands; the A+B carry doubles as the overflow flag.
    always_comb begin
        alu_sum = {1'b0, lat_a} + {1'b0, lat_b};
        alu_out = 6'd0;
        case (lat_op)
            3'b000:  alu_out = alu_sum;
            3'b001:  alu_out = {1'b0, lat_a} - {1'b0, lat_b};
            3'b010:  alu_out = {1'b0, lat_a & lat_b};
            3'b011:  alu_out = {1'b0, lat_a | lat_b};
            3'b100:  alu_out = {1'b0, lat_a ^ lat_b};
            3'b101:  alu_out = {1'b0, ~lat_a};
            3'b110:  alu_out = {lat_a, 1'b0};
            3'b111:  alu_out = {2'b00, lat_a[4:1]};
            default: alu_out = 6'd0;
        endcase
    end

    // Capture the winning request on accept and the result at the end of EXEC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_op   <= 3'd0;
            lat_a    <= 5'd0;
            lat_b    <= 5'd0;
            lat_id   <= 2'd0;
            res_data <= 6'd0;
            res_ovf  <= 1'b0;
        end else begin
            if (accept) begin
                lat_op <= sel_op;
                lat_a  <= sel_a;
                lat_b  <= sel_b;
                lat_id <= grant_idx;
            end
            if (state == EXEC) begin
                res_data <= alu_out;
                res_ovf  <= alu_sum[5];
            end
        end
    end

    // Outputs: grants only in IDLE, response fields forced to zero outside RESP.
    always_comb begin
        req_ready = '0;
        rsp_valid = 1'b0;
        rsp_id    = 2'd0;
        rsp_data  = 6'd0;
        rsp_ovf   = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE: req_ready = grant;
            RESP: begin
                rsp_valid = 1'b1;
                rsp_id    = lat_id;
                rsp_data  = res_data;
                rsp_ovf   = res_ovf;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: self-checking bench for alu_arbiter (N_REQ = 2).
// Responses are checked by a scoreboard queue filled when requests are driven.
module tb_alu_arbiter;

    localparam int N_REQ = 2;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [N_REQ-1:0]   req_valid;
    logic [N_REQ-1:0]   req_ready;
    logic [3*N_REQ-1:0] req_op;
    logic [5*N_REQ-1:0] req_a;
    logic [5*N_REQ-1:0] req_b;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [1:0]         rsp_id;
    logic [5:0]         rsp_data;
    logic               rsp_ovf;
    logic               busy;

    typedef struct {
        int id;
        int op;
        int a;
        int b;
        int exp_data;
        int exp_ovf;
    } vec_t;

    typedef struct {
        int id;
        int data;
        int ovf;
    } rsp_t;

    rsp_t sb_q[$];
    rsp_t mon_exp;
    int   checks   = 0;
    int   failures = 0;

    alu_arbiter #(.N_REQ(N_REQ)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_ovf   (rsp_ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference ALU written in plain integer arithmetic.
    function automatic void model(input int op, input int a, input int b,
                                  output int d, output int o);
        case (op)
            0:       d = (a + b) % 64;
            1:       d = (a - b + 64) % 64;
            2:       d = a & b;
            3:       d = a | b;
            4:       d = a ^ b;
            5:       d = 31 - a;
            6:       d = a * 2;
            default: d = a / 2;
        endcase
        o = ((a + b) > 31) ? 1 : 0;
    endfunction

    // Response monitor: every completed handshake pops one expectation.
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_rsp: got id %0d data %0d expected no response",
                         rsp_id, rsp_data);
            end else begin
                mon_exp = sb_q.pop_front();
                check_output("rsp_id", int'(rsp_id), mon_exp.id);
                check_output("rsp_data", int'(rsp_data), mon_exp.data);
                check_output("rsp_ovf", int'(rsp_ovf), mon_exp.ovf);
            end
        end
    end

    task automatic wait_grant(input int id);
        int got;
        got = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (req_ready[id]) begin
                got = 1;
                break;
            end
        end
        check_output("grant_timeout", got, 1);
    endtask

    task automatic wait_drain();
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (sb_q.size() == 0) break;
        end
        check_output("drain_timeout", sb_q.size(), 0);
    endtask

    task automatic push_exp(input int id, input int d, input int o);
        rsp_t e;
        e.id   = id;
        e.data = d;
        e.ovf  = o;
        sb_q.push_back(e);
    endtask

    task automatic set_req(input int id, input int op, input int a, input int b);
        req_op[3*id +: 3] = 3'(op);
        req_a[5*id +: 5]  = 5'(a);
        req_b[5*id +: 5]  = 5'(b);
    endtask

    // Drive one request, record its expectation, release it after acceptance.
    task automatic apply_stimulus(input int id, input int op, input int a, input int b,
                                  input int exp_d, input int exp_o);
        @(posedge clk);
        #1;
        set_req(id, op, a, b);
        req_valid[id] = 1'b1;
        push_exp(id, exp_d, exp_o);
        wait_grant(id);
        @(posedge clk);
        #1;
        req_valid[id] = 1'b0;
    endtask

    vec_t vecs[12];
    int   exp_ids[4];
    int   acc;
    int   stray;
    int   md;
    int   mo;

    initial begin
        vecs[0]  = '{0, 1, 3, 5, 62, 0};
        vecs[1]  = '{0, 5, 5, 0, 26, 0};
        vecs[2]  = '{1, 0, 31, 31, 62, 1};
        vecs[3]  = '{1, 1, 0, 1, 63, 0};
        vecs[4]  = '{0, 2, 21, 14, 4, 1};
        vecs[5]  = '{1, 3, 16, 1, 17, 0};
        vecs[6]  = '{0, 4, 31, 10, 21, 1};
        vecs[7]  = '{1, 6, 31, 0, 62, 0};
        vecs[8]  = '{0, 7, 31, 31, 15, 1};
        vecs[9]  = '{1, 5, 0, 31, 31, 0};
        vecs[10] = '{0, 1, 5, 3, 2, 0};
        vecs[11] = '{1, 0, 20, 15, 35, 1};
`ifdef ALU_ARB_RR_EN
        exp_ids = '{0, 1, 0, 1};
`else
        exp_ids = '{0, 0, 0, 0};
`endif

        // Reset: outputs quiet, req_ready follows pointer 0 priority.
        rst_n     = 1'b0;
        req_valid = '0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        #12;
        check_output("rst_rsp_valid", int'(rsp_valid), 0);
        check_output("rst_rsp_data", int'(rsp_data), 0);
        check_output("rst_rsp_id", int'(rsp_id), 0);
        check_output("rst_rsp_ovf", int'(rsp_ovf), 0);
        check_output("rst_busy", int'(busy), 0);
        check_output("rst_req_ready_none", int'(req_ready), 0);
        req_valid = 2'b11;
        #1;
        check_output("rst_req_ready_both", int'(req_ready), 1);
        req_valid = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_output("post_rst_busy", int'(busy), 0);
        check_output("post_rst_rsp_valid", int'(rsp_valid), 0);

        // Single op latency, response held with rsp_ready low.
        @(posedge clk);
        #1;
        set_req(0, 0, 20, 15);
        req_valid[0] = 1'b1;
        push_exp(0, 35, 1);
        wait_grant(0);
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        @(negedge clk);
        check_output("exec_busy", int'(busy), 1);
        check_output("exec_rsp_valid", int'(rsp_valid), 0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check_output("lat_rsp_valid", int'(rsp_valid), 1);
        check_output("lat_rsp_id", int'(rsp_id), 0);
        check_output("lat_rsp_data", int'(rsp_data), 35);
        check_output("lat_rsp_ovf", int'(rsp_ovf), 1);
        check_output("lat_req_ready", int'(req_ready), 0);
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        wait_drain();

        // Directed vector table across both requesters.
        for (int i = 0; i < 12; i++) begin
            apply_stimulus(vecs[i].id, vecs[i].op, vecs[i].a, vecs[i].b,
                           vecs[i].exp_data, vecs[i].exp_ovf);
        end
        wait_drain();
        check_output("idle_rsp_data", int'(rsp_data), 0);
        check_output("idle_rsp_id", int'(rsp_id), 0);
        check_output("idle_rsp_ovf", int'(rsp_ovf), 0);
        check_output("idle_busy", int'(busy), 0);

        // Contention: both requesters valid for four accepts.
        @(posedge clk);
        #1;
        set_req(0, 0, 1, 2);
        set_req(1, 4, 25, 12);
        for (int i = 0; i < 4; i++) begin
            if (exp_ids[i] == 0) push_exp(0, 3, 0);
            else                 push_exp(1, 21, 1);
        end
        req_valid = 2'b11;
        acc = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            check_output("ready_onehot", int'($onehot0(req_ready)), 1);
            if (|(req_valid & req_ready)) acc++;
            if (acc == 4) break;
        end
        check_output("contention_accepts", acc, 4);
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        wait_drain();

        // Backpressure: response held, second request stalled not dropped.
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        apply_stimulus(0, 3, 17, 20, 21, 1);
        set_req(1, 0, 1, 1);
        req_valid[1] = 1'b1;
        push_exp(1, 2, 0);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (rsp_valid) break;
        end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check_output("bp_rsp_valid", int'(rsp_valid), 1);
            check_output("bp_rsp_data", int'(rsp_data), 21);
            check_output("bp_req_ready", int'(req_ready), 0);
            check_output("bp_busy", int'(busy), 1);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_output("bp_release_busy", int'(busy), 0);
        check_output("bp_stalled_grant", int'(req_ready), 2);
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        wait_drain();

        // Reset during EXEC abandons the op; next request served from pointer 0.
        @(posedge clk);
        #1;
        set_req(1, 0, 5, 6);
        req_valid[1] = 1'b1;
        wait_grant(1);
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        check_output("mid_exec_busy", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        check_output("mid_rst_busy", int'(busy), 0);
        check_output("mid_rst_rsp_valid", int'(rsp_valid), 0);
        check_output("mid_rst_rsp_id", int'(rsp_id), 0);
        check_output("mid_rst_rsp_data", int'(rsp_data), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        stray = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (rsp_valid) stray++;
        end
        check_output("abandoned_rsp", stray, 0);
        @(posedge clk);
        #1;
        set_req(0, 7, 20, 3);
        set_req(1, 1, 9, 9);
        req_valid = 2'b11;
        push_exp(0, 10, 0);
        wait_grant(0);
        check_output("post_rst_grant", int'(req_ready), 1);
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        wait_drain();

        // Exhaustive opcodes and operands through requester 0.
        for (int op = 0; op < 8; op++) begin
            for (int a = 0; a < 32; a++) begin
                for (int b = 0; b < 32; b++) begin
                    model(op, a, b, md, mo);
                    apply_stimulus(0, op, a, b, md, mo);
                end
            end
        end
        wait_drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
